// File: rtl/latency_meas_ctrl_pkg.sv
// Shared definitions for the latency-measurement session controller:
// default datapath widths, drain length and the session state encoding.
package latency_meas_ctrl_pkg;

  localparam int DEF_TIME_WIDTH   = 16;
  localparam int DEF_SUM_WIDTH    = 32;
  localparam int DEF_MIN_WIDTH    = 16;
  localparam int DEF_MAX_WIDTH    = 16;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int IDX_WIDTH        = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } meas_state_t;

endpackage

// File: rtl/latency_meas_timer.sv
// Loadable down-counter shared by the RUN timeout and the DRAIN wait.
// It stops at zero instead of wrapping, so a stale tick can never re-arm it.
module latency_meas_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;

  // Load has priority; otherwise count down on tick and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (tick && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/latency_meas_ctrl.sv
// Session controller for one latency-measurement window: latches the node
// indices, pulses the datapath enable once per sample, ends on count or
// timeout, lets the datapath pipeline drain and then offers the result.
module latency_meas_ctrl
  import latency_meas_ctrl_pkg::*;
#(
  parameter int TIME_WIDTH   = DEF_TIME_WIDTH,
  parameter int SUM_WIDTH    = DEF_SUM_WIDTH,
  parameter int MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH    = DEF_MAX_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_WIDTH-1:0] cfg_num_samples,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  input  logic [IDX_WIDTH-1:0] cfg_tx_index,
  input  logic [IDX_WIDTH-1:0] cfg_rx_index,
  input  logic                 sample_valid,
  output logic                 meas_en,
  output logic                 meas_finish,
  output logic [IDX_WIDTH-1:0] meas_tx_index,
  output logic [IDX_WIDTH-1:0] meas_rx_index,
  input  logic [SUM_WIDTH-1:0] lat_sum_in,
  input  logic [MIN_WIDTH-1:0] lat_min_in,
  input  logic [MAX_WIDTH-1:0] lat_max_in,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SUM_WIDTH-1:0] res_sum,
  output logic [MIN_WIDTH-1:0] res_min,
  output logic [MAX_WIDTH-1:0] res_max,
  output logic [CNT_WIDTH-1:0] res_count,
  output logic                 res_timeout
);

  // The drain must outlast the datapath EN-to-sum latency of 3 cycles.
  if (DRAIN_CYCLES < 3 || TIME_WIDTH < 1) begin : g_param_check
    $error("latency_meas_ctrl: DRAIN_CYCLES must be >= 3");
  end

  // Drain wait is DRAIN_CYCLES states, so the down-counter starts one lower.
  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);

  meas_state_t state_reg, state_next;
  logic [CNT_WIDTH-1:0] num_reg, num_next, tmo_reg, tmo_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [SUM_WIDTH-1:0] base_reg, base_next;
  logic                 tflag_reg, tflag_next;
  logic                 meas_en_reg, meas_en_next, finish_reg, finish_next;
  logic [IDX_WIDTH-1:0] tx_reg, tx_next, rx_reg, rx_next;
  logic                 busy_reg, busy_next, res_valid_reg, res_valid_next;
  logic [SUM_WIDTH-1:0] res_sum_reg, res_sum_next;
  logic [MIN_WIDTH-1:0] res_min_reg, res_min_next;
  logic [MAX_WIDTH-1:0] res_max_reg, res_max_next;
  logic [CNT_WIDTH-1:0] res_count_reg, res_count_next;
  logic                 res_tmo_reg, res_tmo_next;
  logic                 tmr_load, tmr_tick, tmr_zero, cnt_done, tmo_hit;
  logic [CNT_WIDTH-1:0] tmr_val;

  latency_meas_timer #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .zero     (tmr_zero)
  );

  // Sample counter saturates at all-ones rather than wrapping.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  // Next-state and next-output logic; abort overrides everything at the end.
  always_comb begin
    state_next     = state_reg;
    num_next       = num_reg;
    tmo_next       = tmo_reg;
    cnt_next       = cnt_reg;
    base_next      = base_reg;
    tflag_next     = tflag_reg;
    meas_en_next   = 1'b0;
    finish_next    = finish_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    res_valid_next = res_valid_reg;
    res_sum_next   = res_sum_reg;
    res_min_next   = res_min_reg;
    res_max_next   = res_max_reg;
    res_count_next = res_count_reg;
    res_tmo_next   = res_tmo_reg;
    tmr_load       = 1'b0;
    tmr_val        = DRAIN_LOAD;
    tmr_tick       = 1'b0;
    cnt_done       = 1'b0;
    tmo_hit        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        finish_next = 1'b1;
        if (cfg_start && !cfg_abort) begin
          num_next   = cfg_num_samples;
          tmo_next   = cfg_timeout;
          tx_next    = cfg_tx_index;
          rx_next    = cfg_rx_index;
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        base_next   = lat_sum_in;
        cnt_next    = '0;
        tflag_next  = 1'b0;
        finish_next = 1'b0;
        tmr_load    = 1'b1;
        if (num_reg == '0) begin
          tmr_val    = DRAIN_LOAD;
          state_next = ST_DRAIN;
        end else begin
          // Counter hits zero on RUN cycle index timeout-1.
          tmr_val    = tmo_reg - 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        meas_en_next = sample_valid;
        tmr_tick     = 1'b1;
        if (sample_valid) begin
          cnt_next = cnt_inc;
        end
        cnt_done = sample_valid && (cnt_inc == num_reg);
        tmo_hit  = (tmo_reg != '0) && tmr_zero;
        if (tmo_hit) begin
          tflag_next = 1'b1;
        end
        if (cnt_done || tmo_hit) begin
          tmr_load   = 1'b1;
          tmr_val    = DRAIN_LOAD;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        finish_next = 1'b0;
        tmr_tick    = 1'b1;
        if (tmr_zero) begin
          // Modular subtraction absorbs a wrap of the datapath sum.
          res_sum_next   = lat_sum_in - base_reg;
          res_min_next   = lat_min_in;
          res_max_next   = lat_max_in;
          res_count_next = cnt_reg;
          res_tmo_next   = tflag_reg;
          res_valid_next = 1'b1;
          finish_next    = 1'b1;
          state_next     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (cfg_abort && (state_reg != ST_IDLE)) begin
      state_next     = ST_IDLE;
      meas_en_next   = 1'b0;
      finish_next    = 1'b1;
      res_valid_next = 1'b0;
      res_sum_next   = res_sum_reg;
      res_min_next   = res_min_reg;
      res_max_next   = res_max_reg;
      res_count_next = res_count_reg;
      res_tmo_next   = res_tmo_reg;
      tmr_load       = 1'b0;
      tmr_tick       = 1'b0;
    end
    busy_next = (state_next != ST_IDLE);
  end

  // State and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      num_reg       <= '0;
      tmo_reg       <= '0;
      cnt_reg       <= '0;
      base_reg      <= '0;
      tflag_reg     <= 1'b0;
      meas_en_reg   <= 1'b0;
      finish_reg    <= 1'b1;
      tx_reg        <= '0;
      rx_reg        <= '0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_sum_reg   <= '0;
      res_min_reg   <= '0;
      res_max_reg   <= '0;
      res_count_reg <= '0;
      res_tmo_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      num_reg       <= num_next;
      tmo_reg       <= tmo_next;
      cnt_reg       <= cnt_next;
      base_reg      <= base_next;
      tflag_reg     <= tflag_next;
      meas_en_reg   <= meas_en_next;
      finish_reg    <= finish_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      busy_reg      <= busy_next;
      res_valid_reg <= res_valid_next;
      res_sum_reg   <= res_sum_next;
      res_min_reg   <= res_min_next;
      res_max_reg   <= res_max_next;
      res_count_reg <= res_count_next;
      res_tmo_reg   <= res_tmo_next;
    end
  end

  assign meas_en       = meas_en_reg;
  assign meas_finish   = finish_reg;
  assign meas_tx_index = tx_reg;
  assign meas_rx_index = rx_reg;
  assign busy          = busy_reg;
  assign res_valid     = res_valid_reg;
  assign res_sum       = res_sum_reg;
  assign res_min       = res_min_reg;
  assign res_max       = res_max_reg;
  assign res_count     = res_count_reg;
  assign res_timeout   = res_tmo_reg;

endmodule

// File: tb/tb_latency_meas_ctrl.sv
// Randomized bench for latency_meas_ctrl with a small latency-datapath model,
// a session-level reference model and a result scoreboard.
module tb_latency_meas_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_num_samples = '0, cfg_timeout = '0;
  logic [4:0]  cfg_tx_index = '0, cfg_rx_index = '0;
  logic        sample_valid = 1'b0, res_ready = 1'b0;
  logic        meas_en, meas_finish, busy, res_valid, res_timeout;
  logic [4:0]  meas_tx_index, meas_rx_index;
  logic [31:0] res_sum;
  logic [15:0] res_min, res_max, res_count;

  // Datapath model: EN plus the sample's latency travel two stages, then accumulate.
  logic [15:0] cur_lat = '0, lat_d1 = '0, p1_lat = '0, p2_lat = '0;
  logic        p1_en = 1'b0, p2_en = 1'b0;
  logic [31:0] dp_sum = '0;
  logic [15:0] dp_min = 16'hFFFF, dp_max = '0;
  logic        dp_preset = 1'b0;
  logic [31:0] dp_preset_val = '0;

  int cyc = 0;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] sum;
    logic [15:0] mn, mx, count;
    logic        tmo;
    logic [4:0]  tx, rx;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_res;
  logic [15:0] ref_min = 16'hFFFF, ref_max = '0;

  latency_meas_ctrl #(
    .TIME_WIDTH(16), .SUM_WIDTH(32), .MIN_WIDTH(16), .MAX_WIDTH(16),
    .CNT_WIDTH(16), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_samples(cfg_num_samples), .cfg_timeout(cfg_timeout),
    .cfg_tx_index(cfg_tx_index), .cfg_rx_index(cfg_rx_index),
    .sample_valid(sample_valid),
    .meas_en(meas_en), .meas_finish(meas_finish),
    .meas_tx_index(meas_tx_index), .meas_rx_index(meas_rx_index),
    .lat_sum_in(dp_sum), .lat_min_in(dp_min), .lat_max_in(dp_max),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_min(res_min), .res_max(res_max),
    .res_count(res_count), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    lat_d1 <= cur_lat;
    p1_en  <= meas_en;
    p1_lat <= lat_d1;
    p2_en  <= p1_en;
    p2_lat <= p1_lat;
    if (dp_preset) dp_sum <= dp_preset_val;
    else if (p2_en) dp_sum <= dp_sum + 32'(p2_lat);
    if (p2_en && p2_lat < dp_min) dp_min <= p2_lat;
    if (p2_en && p2_lat > dp_max) dp_max <= p2_lat;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_sample(input logic [15:0] lat);
    if (lat < ref_min) ref_min = lat;
    if (lat > ref_max) ref_max = lat;
  endtask

  // Scoreboard monitor: pops an expectation whenever a result appears.
  initial begin : monitor
    exp_t cur;
    logic rv_prev;
    int en_cnt;
    rv_prev = 1'b0;
    en_cnt = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev = 1'b0;
        en_cnt = 0;
      end else begin
        if (!busy) begin
          check("idle_meas_en", meas_en, 1'b0);
          en_cnt = 0;
        end else if (meas_en) begin
          en_cnt++;
        end
        if (res_valid && !rv_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", res_valid, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            check("res_cycle", cyc, cur.cyc);
            check("res_sum", res_sum, cur.sum);
            check("res_min", res_min, cur.mn);
            check("res_max", res_max, cur.mx);
            check("res_count", res_count, cur.count);
            check("res_timeout", res_timeout, cur.tmo);
            check("en_pulses", en_cnt, cur.count);
            check("tx_index", meas_tx_index, cur.tx);
            check("rx_index", meas_rx_index, cur.rx);
            check("finish_report", meas_finish, 1'b1);
          end
        end else if (res_valid) begin
          check("hold_sum", res_sum, cur.sum);
          check("hold_count", res_count, cur.count);
          check("hold_min", res_min, cur.mn);
          check("hold_timeout", res_timeout, cur.tmo);
        end
        rv_prev = res_valid;
      end
    end
  end

  // One measurement session; the reference decides the window from the rules.
  task automatic run_session(input int num, input int tmo, input int prob,
                             input int max_sv, input int lat_fix, input int hold);
    exp_t e;
    int s, j, cnt, offered, k, vcnt;
    logic done, sv, accepted;
    logic [15:0] lat;
    logic [31:0] sum;
    e = '{default: '0};
    e.tx = 5'($urandom);
    e.rx = 5'($urandom);
    s = cyc;
    cfg_num_samples = 16'(num);
    cfg_timeout = 16'(tmo);
    cfg_tx_index = e.tx;
    cfg_rx_index = e.rx;
    cfg_start = 1'b1;
    sample_valid = 1'($urandom_range(0, 1));
    step();
    cfg_start = 1'b0;
    cfg_num_samples = 16'($urandom);
    cfg_timeout = 16'($urandom);
    cfg_tx_index = 5'($urandom);
    cfg_rx_index = 5'($urandom);
    sample_valid = 1'($urandom_range(0, 1));
    step();
    cnt = 0; offered = 0; j = 0; sum = '0; done = 1'b0;
    if (num == 0) begin
      e.cyc = s + 2 + DC;
    end else begin
      while (!done) begin
        sv = (offered < max_sv) && ($urandom_range(0, 99) < prob);
        lat = (lat_fix != 0) ? 16'(lat_fix) : 16'($urandom_range(1, 1000));
        sample_valid = sv;
        cur_lat = lat;
        if (sv) begin
          offered++;
          cnt++;
          sum = sum + 32'(lat);
          note_sample(lat);
          if (cnt == num) done = 1'b1;
        end
        if (tmo != 0 && j == tmo - 1) begin
          e.tmo = 1'b1;
          done = 1'b1;
        end
        if (j == 0) begin
          @(negedge clk);
          check("run_finish_low", meas_finish, 1'b0);
          check("run_busy", busy, 1'b1);
        end
        if (!done) begin
          if (j > 4000) begin
            check("window_bound", 1'b0, 1'b1);
            done = 1'b1;
          end else begin
            j++;
            step();
          end
        end
      end
      e.cyc = s + 3 + j + DC;
    end
    e.sum = sum;
    e.count = 16'(cnt);
    e.mn = ref_min;
    e.mx = ref_max;
    exp_q.push_back(e);
    accepted = 1'b0; k = 0; vcnt = 0;
    while (!accepted && k < 400) begin
      step();
      sample_valid = 1'($urandom_range(0, 1));
      cur_lat = 16'($urandom_range(1, 1000));
      res_ready = (hold > 0) ? (vcnt >= hold) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (res_valid && res_ready) begin
        accepted = 1'b1;
      end else if (res_valid) begin
        vcnt++;
        if (hold > 0) check("hold_busy", busy, 1'b1);
      end
      k++;
    end
    if (!accepted) check("handshake_bound", accepted, 1'b1);
    step();
    res_ready = 1'b0;
    @(negedge clk);
    check("idle_after_ack_busy", busy, 1'b0);
    check("idle_after_ack_valid", res_valid, 1'b0);
    repeat (3) begin
      step();
      sample_valid = 1'($urandom_range(0, 1));
    end
    last_res = e;
  endtask

  task automatic check_res_unchanged(input string tag);
    check({tag, "_sum"}, res_sum, last_res.sum);
    check({tag, "_count"}, res_count, last_res.count);
    check({tag, "_min"}, res_min, last_res.mn);
    check({tag, "_timeout"}, res_timeout, last_res.tmo);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish by 2000000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] l0, l2;
    last_res = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_meas_en", meas_en, 1'b0);
    check("rst_meas_finish", meas_finish, 1'b1);
    check("rst_tx", meas_tx_index, 5'd0);
    check("rst_rx", meas_rx_index, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_sum", res_sum, 32'd0);
    check("rst_res_min", res_min, 16'd0);
    check("rst_res_max", res_max, 16'd0);
    check("rst_res_count", res_count, 16'd0);
    check("rst_res_timeout", res_timeout, 1'b0);
    rst_n = 1'b1;
    step();

    run_session(5, 0, 60, 5, 10, 0);      // normal: sum 0 -> 50
    run_session(10, 20, 100, 3, 0, 0);    // timeout after 20 RUN cycles
    dp_preset_val = 32'hFFFF_FFF0;        // wrap: end value 0x10
    dp_preset = 1'b1;
    step();
    dp_preset = 1'b0;
    run_session(2, 0, 100, 2, 16, 0);
    run_session(0, 0, 50, 0, 0, 0);       // zero samples
    run_session(3, 0, 70, 3, 0, 7);       // back-pressure on the result

    // Abort in RUN after two samples, with a start in the same cycle.
    cfg_num_samples = 16'd10; cfg_timeout = 16'd0; cfg_start = 1'b1; sample_valid = 1'b0;
    step();
    cfg_start = 1'b0;
    step();
    l0 = 16'($urandom_range(1, 1000));
    l2 = 16'($urandom_range(1, 1000));
    sample_valid = 1'b1; cur_lat = l0; note_sample(l0);
    step();
    sample_valid = 1'b0;
    step();
    sample_valid = 1'b1; cur_lat = l2; note_sample(l2);
    step();
    sample_valid = 1'b0; cfg_abort = 1'b1; cfg_start = 1'b1;
    step();
    cfg_abort = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_finish", meas_finish, 1'b1);
    check("abort_valid", res_valid, 1'b0);
    check_res_unchanged("abort_res");
    step();
    @(negedge clk);
    check("abort_start_ignored", busy, 1'b0);
    repeat (4) step();

    // Asynchronous reset in the middle of RUN.
    cfg_num_samples = 16'd5; cfg_timeout = 16'd0; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_finish", meas_finish, 1'b1);
    check("arst_tx", meas_tx_index, 5'd0);
    check("arst_valid", res_valid, 1'b0);
    last_res = '{default: '0};
    check_res_unchanged("arst_res");
    step();
    rst_n = 1'b1;
    repeat (4) step();

    for (int i = 0; i < 25; i++) begin
      run_session($urandom_range(0, 8),
                  ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30),
                  $urandom_range(20, 100), 1000, 0, 0);
    end

    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
